// File: rtl/uart_rx_fifo_fpga.sv
// uart_rx_fifo_fpga: UART receiver (start, WIDTH LSB-first bits ending in odd parity, stop) into a show-ahead FIFO.
// Latency: word appears at rx_data one clk after the stop-bit decision (line to rx_d2 adds 2 clk).
// Backpressure: none on the line; a good frame arriving while full and not popped is dropped and sets overflow.
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN (2-of-3 majority per bit, OVERSAMPLE >= 4).
module uart_rx_fifo_fpga #(
  parameter int WIDTH      = 64,
  parameter int OVERSAMPLE = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rx_in,
  input  logic                          rd_en,
  input  logic                          clr_errors,
  output logic [WIDTH-1:0]              rx_data,
  output logic                          parity_error,
  output logic                          rx_empty,
  output logic                          rx_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          framing_error,
  output logic                          overflow
);

  localparam int HALF = OVERSAMPLE / 2;
  localparam int PH_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);

  // The start decision point sets the bit-relative phase of every later
  // decision: DATA and STOP decide every OVERSAMPLE cycles after it.
  // Single sampling decides at bit phase HALF; majority decides at HALF+1,
  // once the third vote is in.
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int START_PH = HALF;
`else
  localparam int START_PH = (HALF > 0) ? HALF - 1 : 0;
`endif

  localparam logic [PH_W-1:0] START_PH_C = PH_W'(START_PH);
  localparam logic [PH_W-1:0] LAST_PH_C  = PH_W'(OVERSAMPLE - 1);
  localparam logic [7:0]      LAST_BIT_C = 8'(WIDTH - 1);
  localparam logic [AW:0]     DEPTH_C    = (AW + 1)'(FIFO_DEPTH);

  // Parameter legality is checked at elaboration.
  if (WIDTH < 2 || WIDTH > 255) begin : g_bad_width
    $error("uart_rx_fifo_fpga: WIDTH must be in 2..255");
  end
  if (OVERSAMPLE < 1 || OVERSAMPLE > 64) begin : g_bad_os
    $error("uart_rx_fifo_fpga: OVERSAMPLE must be in 1..64");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo_fpga: FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [7:0]        bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              rx_d1_q, rx_d1_d;
  logic              rx_d2_q, rx_d2_d;
  logic              framing_q, framing_d;
  logic              overflow_q, overflow_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [WIDTH:0]    mem_q [FIFO_DEPTH];

  logic              sample;
  logic              push_req;
  logic              frame_err_set;
  logic              par_err;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              empty;
  logic              full;
  logic [WIDTH:0]    head;

  // Two-flop synchroniser on the asynchronous line.
  always_comb begin
    rx_d1_d = rx_in;
    rx_d2_d = rx_d1_q;
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  if (OVERSAMPLE < 4) begin : g_bad_vote
    $error("uart_rx_fifo_fpga: UART_RX_MAJORITY_VOTE_EN needs OVERSAMPLE >= 4");
  end

  logic [1:0] hist_q, hist_d;

  // Keep the two previous synchronised samples for the vote.
  always_comb hist_d = {hist_q[0], rx_d2_q};

  // History register; idles high like the line.
  always_ff @(posedge clk) begin
    if (!reset_n) hist_q <= 2'b11;
    else          hist_q <= hist_d;
  end

  // 2-of-3 vote over the last three cycles ending at the decision cycle.
  always_comb sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_d2_q) | (hist_q[0] & rx_d2_q);
`else
  // Single mid-bit sample.
  always_comb sample = rx_d2_q;
`endif

  // Odd parity over the whole word: an even number of ones is an error.
  always_comb par_err = ~(^shift_q);

  // Receive FSM next-state: bit timing, shifting and frame verdict.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    push_req      = 1'b0;
    frame_err_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_d2_q) begin
          state_d = START;
          phase_d = '0;
        end
      end
      START: begin
        if (phase_q == START_PH_C) begin
          phase_d = '0;
          if (!sample) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      DATA: begin
        if (phase_q == LAST_PH_C) begin
          phase_d = '0;
          // Shifting in from the top leaves the first (LSB) bit at index 0.
          shift_d = {sample, shift_q[WIDTH-1:1]};
          if (bit_cnt_q == LAST_BIT_C) state_d = STOP;
          else                         bit_cnt_d = bit_cnt_q + 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      STOP: begin
        if (phase_q == LAST_PH_C) begin
          phase_d = '0;
          if (sample) begin
            push_req = 1'b1;
            state_d  = IDLE;
          end else begin
            frame_err_set = 1'b1;
            state_d       = WAIT_IDLE;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        // A break or stuck-low line must return high before re-arming.
        if (rx_d2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO control: push/pop arbitration, pointers, count and sticky flags.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == DEPTH_C);
    pop        = rd_en & ~empty;
    push       = push_req & (~full | pop);
    ovf_set    = push_req & full & ~pop;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Set wins over a simultaneous clear.
    framing_d  = (framing_q  & ~clr_errors) | frame_err_set;
    overflow_d = (overflow_q & ~clr_errors) | ovf_set;
  end

  // Control and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_d1_q    <= 1'b1;
      rx_d2_q    <= 1'b1;
      framing_q  <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_d1_q    <= rx_d1_d;
      rx_d2_q    <= rx_d2_d;
      framing_q  <= framing_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage array, not reset; entry is {parity flag, word}.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {par_err, shift_q};
  end

  // Show-ahead head and status outputs; data is forced to 0 when empty.
  always_comb begin
    head          = mem_q[rd_ptr_q];
    rx_data       = empty ? '0 : head[WIDTH-1:0];
    parity_error  = ~empty & head[WIDTH];
    rx_empty      = empty;
    rx_full       = full;
    fifo_count    = count_q;
    framing_error = framing_q;
    overflow      = overflow_q;
  end

endmodule

// File: tb/tb_uart_rx_fifo_fpga.sv
// tb_uart_rx_fifo_fpga: directed bench for uart_rx_fifo_fpga (WIDTH=64, OVERSAMPLE=4, FIFO_DEPTH=4).
// Latency: expects the word one clk after the stop decision (two with UART_RX_MAJORITY_VOTE_EN).
// Backpressure: exercises overflow drop and push+pop while full.
module tb_uart_rx_fifo_fpga;

  localparam int WIDTH = 64;
  localparam int OS    = 4;
  localparam int DEPTH = 4;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [63:0] W_GOOD   = 64'h8123_4567_89AB_CDEF;
  localparam logic [63:0] W_BADPAR = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W_BREAK  = 64'hDEAD_BEEF_0000_1111;
  localparam logic [63:0] W_A      = 64'h0000_0000_0000_0001;
  localparam logic [63:0] W_B      = 64'h0000_0000_0000_0003;
  localparam logic [63:0] W_C      = 64'h0000_0000_0000_0007;
  localparam logic [63:0] W_D      = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] W_E      = 64'h5555_5555_5555_5555;
  localparam logic [63:0] W_F      = 64'hA5A5_0F0F_F0F0_5A5B;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             rx_in;
  logic             rd_en;
  logic             clr_errors;
  logic [WIDTH-1:0] rx_data;
  logic             parity_error;
  logic             rx_empty;
  logic             rx_full;
  logic [2:0]       fifo_count;
  logic             framing_error;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_fpga #(
    .WIDTH(WIDTH),
    .OVERSAMPLE(OS),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx_in(rx_in),
    .rd_en(rd_en),
    .clr_errors(clr_errors),
    .rx_data(rx_data),
    .parity_error(parity_error),
    .rx_empty(rx_empty),
    .rx_full(rx_full),
    .fifo_count(fifo_count),
    .framing_error(framing_error),
    .overflow(overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (OS) tick();
  endtask

  // Returns in the stop-bit sample cycle with the line left at the stop value.
  task automatic send_frame(input logic [WIDTH-1:0] w, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < WIDTH; i++) send_bit(w[i]);
    rx_in = stop_bit;
    repeat (OS) tick();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    rx_in      = 1'b1;
    rd_en      = 1'b0;
    clr_errors = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({rx_empty, rx_full, fifo_count, framing_error, overflow, parity_error} !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected %b",
               {rx_empty, rx_full, fifo_count, framing_error, overflow, parity_error}, 8'b1000_0000);
    end
    n_checks++;
    if (rx_data !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected %h", rx_data, 64'd0);
    end
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_good_frame();
    send_frame(W_GOOD, 1'b1);
    repeat (LAT - 1) tick();
    n_checks++;
    if (rx_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_at_stop_sample: got %b expected %b", rx_empty, 1'b1);
    end
    tick();
    n_checks++;
    if ({rx_empty, fifo_count, parity_error} !== 5'b0_001_0) begin
      n_fail++;
      $display("FAIL good_flags: got %b expected %b", {rx_empty, fifo_count, parity_error}, 5'b0_001_0);
    end
    n_checks++;
    if (rx_data !== W_GOOD) begin
      n_fail++;
      $display("FAIL good_data: got %h expected %h", rx_data, W_GOOD);
    end
    pop();
    n_checks++;
    if ({rx_empty, fifo_count} !== 4'b1_000 || rx_data !== 64'd0) begin
      n_fail++;
      $display("FAIL good_pop: got empty/count %b data %h expected 1000 data 0", {rx_empty, fifo_count}, rx_data);
    end
  endtask

  task automatic test_parity();
    send_frame(W_BADPAR, 1'b1);
    repeat (LAT) tick();
    n_checks++;
    if (rx_data !== W_BADPAR) begin
      n_fail++;
      $display("FAIL parity_data: got %h expected %h", rx_data, W_BADPAR);
    end
    n_checks++;
    if ({parity_error, framing_error, fifo_count} !== 5'b1_0_001) begin
      n_fail++;
      $display("FAIL parity_flags: got %b expected %b", {parity_error, framing_error, fifo_count}, 5'b1_0_001);
    end
    pop();
  endtask

  task automatic test_framing();
    send_frame(W_BREAK, 1'b0);
    repeat (3 * OS) tick();
    rx_in = 1'b1;
    repeat (2 * OS) tick();
    n_checks++;
    if ({framing_error, fifo_count} !== 4'b1_000) begin
      n_fail++;
      $display("FAIL framing_set: got %b expected %b", {framing_error, fifo_count}, 4'b1_000);
    end
    send_frame(W_GOOD, 1'b1);
    repeat (LAT) tick();
    n_checks++;
    if ({framing_error, fifo_count, parity_error} !== 5'b1_001_0 || rx_data !== W_GOOD) begin
      n_fail++;
      $display("FAIL framing_after_good: got flags %b data %h expected 10010 data %h",
               {framing_error, fifo_count, parity_error}, rx_data, W_GOOD);
    end
    clr_errors = 1'b1;
    tick();
    clr_errors = 1'b0;
    n_checks++;
    if (framing_error !== 1'b0) begin
      n_fail++;
      $display("FAIL framing_clear: got %b expected %b", framing_error, 1'b0);
    end
    pop();
  endtask

  task automatic test_glitch();
    rx_in = 1'b0;
    tick();
    rx_in = 1'b1;
    repeat (4 * OS) tick();
    n_checks++;
    if ({rx_empty, fifo_count, framing_error} !== 5'b1_000_0) begin
      n_fail++;
      $display("FAIL glitch_no_frame: got %b expected %b", {rx_empty, fifo_count, framing_error}, 5'b1_000_0);
    end
    send_frame(W_C, 1'b1);
    repeat (LAT) tick();
    n_checks++;
    if (fifo_count !== 3'd1 || rx_data !== W_C) begin
      n_fail++;
      $display("FAIL glitch_rearm: got count %0d data %h expected count 1 data %h", fifo_count, rx_data, W_C);
    end
    pop();
  endtask

  task automatic test_back_to_back_overflow();
    logic [63:0] exp_w [4];
    exp_w[0] = W_A; exp_w[1] = W_B; exp_w[2] = W_C; exp_w[3] = W_D;
    send_frame(W_A, 1'b1);
    send_frame(W_B, 1'b1);
    send_frame(W_C, 1'b1);
    send_frame(W_D, 1'b1);
    send_frame(W_E, 1'b1);
    repeat (LAT) tick();
    n_checks++;
    if ({fifo_count, rx_full, overflow, framing_error} !== 6'b100_1_1_0) begin
      n_fail++;
      $display("FAIL overflow_flags: got %b expected %b", {fifo_count, rx_full, overflow, framing_error}, 6'b100_1_1_0);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rx_data !== exp_w[i]) begin
        n_fail++;
        $display("FAIL overflow_order[%0d]: got %h expected %h", i, rx_data, exp_w[i]);
      end
      pop();
    end
    n_checks++;
    if ({rx_empty, fifo_count} !== 4'b1_000) begin
      n_fail++;
      $display("FAIL overflow_drained: got %b expected %b", {rx_empty, fifo_count}, 4'b1_000);
    end
    // Pop when empty is ignored.
    pop();
    n_checks++;
    if ({rx_empty, fifo_count} !== 4'b1_000) begin
      n_fail++;
      $display("FAIL pop_empty: got %b expected %b", {rx_empty, fifo_count}, 4'b1_000);
    end
    clr_errors = 1'b1;
    tick();
    clr_errors = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear: got %b expected %b", overflow, 1'b0);
    end
  endtask

  task automatic test_push_pop_full();
    logic [63:0] exp_w [4];
    exp_w[0] = W_B; exp_w[1] = W_C; exp_w[2] = W_D; exp_w[3] = W_F;
    send_frame(W_A, 1'b1);
    send_frame(W_B, 1'b1);
    send_frame(W_C, 1'b1);
    send_frame(W_D, 1'b1);
    send_frame(W_F, 1'b1);
    repeat (LAT - 1) tick();
    n_checks++;
    if ({fifo_count, rx_full} !== 4'b100_1) begin
      n_fail++;
      $display("FAIL full_before_pushpop: got %b expected %b", {fifo_count, rx_full}, 4'b100_1);
    end
    pop();
    n_checks++;
    if ({fifo_count, rx_full, overflow} !== 5'b100_1_0) begin
      n_fail++;
      $display("FAIL pushpop_full: got %b expected %b", {fifo_count, rx_full, overflow}, 5'b100_1_0);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rx_data !== exp_w[i]) begin
        n_fail++;
        $display("FAIL pushpop_order[%0d]: got %h expected %h", i, rx_data, exp_w[i]);
      end
      pop();
    end
  endtask

  task automatic test_mid_frame_reset();
    send_frame(W_B, 1'b1);
    repeat (LAT) tick();
    n_checks++;
    if ({fifo_count, parity_error} !== 4'b001_1 || rx_data !== W_B) begin
      n_fail++;
      $display("FAIL prereset_word: got %b data %h expected 0011 data %h", {fifo_count, parity_error}, rx_data, W_B);
    end
    send_bit(1'b0);
    for (int i = 0; i < 20; i++) send_bit(W_E[i]);
    reset_n = 1'b0;
    rx_in   = 1'b1;
    tick();
    reset_n = 1'b1;
    n_checks++;
    if ({rx_empty, rx_full, fifo_count, framing_error, overflow, parity_error} !== 8'b1000_0000 || rx_data !== 64'd0) begin
      n_fail++;
      $display("FAIL midframe_reset: got %b data %h expected 10000000 data 0",
               {rx_empty, rx_full, fifo_count, framing_error, overflow, parity_error}, rx_data);
    end
    repeat (3 * OS * WIDTH / 4) tick();
    n_checks++;
    if (fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL midframe_no_push: got %0d expected %0d", fifo_count, 0);
    end
    send_frame(W_GOOD, 1'b1);
    repeat (LAT) tick();
    n_checks++;
    if (fifo_count !== 3'd1 || rx_data !== W_GOOD || parity_error !== 1'b0) begin
      n_fail++;
      $display("FAIL postreset_frame: got count %0d data %h par %b expected 1 %h 0",
               fifo_count, rx_data, parity_error, W_GOOD);
    end
    pop();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity();
    test_framing();
    test_glitch();
    test_back_to_back_overflow();
    test_push_pop_full();
    test_mid_frame_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
